// File: rtl/t2mi_frame_scheduler.sv
// Per-T2-frame arbiter for the T2-MI payload bus: one L1-current packet, then BB_PER_FRAME BBFRAMEs.
// Optional L1 watchdog is built in when the macro L1_TIMEOUT_EN is defined.
module t2mi_frame_scheduler #(
  parameter int L1_LEN       = 67,
  parameter int BB_PER_FRAME = 4,
  parameter int BB_LEN       = 2000,
  parameter int L1_TIMEOUT   = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       FRAME_TICK,
  output logic       L1_REQ,
  input  logic [7:0] L1_DATA,
  input  logic       L1_LOAD,
  input  logic       BB_READY,
  output logic       BB_REQ,
  input  logic [7:0] BB_DATA,
  input  logic       BB_VALID,
  output logic [7:0] OUT_DATA,
  output logic       OUT_LOAD,
  output logic       OUT_SOF,
  output logic       OUT_EOF,
  output logic [7:0] OUT_TYPE,
  output logic [7:0] FRAME_IDX,
  output logic       OVERRUN,
  output logic       L1_ERR
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] L1_START = 3'd1;
  localparam logic [2:0] L1_XFER  = 3'd2;
  localparam logic [2:0] BB_WAIT  = 3'd3;
  localparam logic [2:0] BB_XFER  = 3'd4;

  localparam logic [15:0] L1_LAST  = 16'(L1_LEN - 1);
  localparam logic [15:0] BB_LAST  = 16'(BB_LEN - 1);
  localparam logic [7:0]  BB_COUNT = 8'(BB_PER_FRAME);
  localparam logic [7:0]  TYPE_L1  = 8'h10;
  localparam logic [7:0]  TYPE_BB  = 8'h00;

  // Counters are 16/8 bits wide, so parameters outside these ranges can never match.
  if (L1_LEN < 1 || L1_LEN > 65535 || BB_LEN < 1 || BB_LEN > 65535 ||
      BB_PER_FRAME < 1 || BB_PER_FRAME > 255 || L1_TIMEOUT < 1 || L1_TIMEOUT > 65535)
  begin : g_bad_params
    $error("t2mi_frame_scheduler: parameter out of range");
  end

  logic [2:0]  state;
  logic [15:0] byte_cnt;
  logic [7:0]  bb_cnt;
  logic        l1_timeout;

`ifdef L1_TIMEOUT_EN
  localparam logic [15:0] IDLE_LIMIT = 16'(L1_TIMEOUT);

  logic [15:0] idle_cnt;
  logic        l1_err;

  assign l1_timeout = (state == L1_XFER) && !L1_LOAD && (idle_cnt + 16'd1 == IDLE_LIMIT);
  assign L1_ERR     = l1_err;

  // Idle counter only runs while an L1 transfer is stalled; any byte restarts it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt <= '0;
      l1_err   <= 1'b0;
    end else begin
      if (state != L1_XFER || L1_LOAD)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 16'd1;
      if (l1_timeout)
        l1_err <= 1'b1;
    end
  end
`else
  assign l1_timeout = 1'b0;
  assign L1_ERR     = 1'b0;
`endif

  // Single register stage: every accepted byte is tagged and presented on the next cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      bb_cnt    <= '0;
      L1_REQ    <= 1'b0;
      BB_REQ    <= 1'b0;
      OUT_DATA  <= '0;
      OUT_LOAD  <= 1'b0;
      OUT_SOF   <= 1'b0;
      OUT_EOF   <= 1'b0;
      OUT_TYPE  <= '0;
      FRAME_IDX <= '0;
      OVERRUN   <= 1'b0;
    end else begin
      OUT_LOAD <= 1'b0;
      OUT_SOF  <= 1'b0;
      OUT_EOF  <= 1'b0;
      L1_REQ   <= 1'b0;

      if (FRAME_TICK && state != IDLE)
        OVERRUN <= 1'b1;

      case (state)
        IDLE: begin
          if (FRAME_TICK) begin
            state  <= L1_START;
            L1_REQ <= 1'b1;
          end
        end

        L1_START: begin
          byte_cnt <= '0;
          state    <= L1_XFER;
        end

        L1_XFER: begin
          if (L1_LOAD) begin
            OUT_DATA <= L1_DATA;
            OUT_LOAD <= 1'b1;
            OUT_SOF  <= (byte_cnt == 16'd0);
            OUT_EOF  <= (byte_cnt == L1_LAST);
            OUT_TYPE <= TYPE_L1;
            byte_cnt <= byte_cnt + 16'd1;
            if (byte_cnt == L1_LAST) begin
              state  <= BB_WAIT;
              bb_cnt <= '0;
            end
          end else if (l1_timeout) begin
            state  <= BB_WAIT;
            bb_cnt <= '0;
          end
        end

        BB_WAIT: begin
          if (BB_READY) begin
            state    <= BB_XFER;
            BB_REQ   <= 1'b1;
            byte_cnt <= '0;
          end
        end

        BB_XFER: begin
          if (BB_VALID) begin
            OUT_DATA <= BB_DATA;
            OUT_LOAD <= 1'b1;
            OUT_SOF  <= (byte_cnt == 16'd0);
            OUT_EOF  <= (byte_cnt == BB_LAST);
            OUT_TYPE <= TYPE_BB;
            byte_cnt <= byte_cnt + 16'd1;
            if (byte_cnt == BB_LAST) begin
              BB_REQ <= 1'b0;
              bb_cnt <= bb_cnt + 8'd1;
              if (bb_cnt + 8'd1 == BB_COUNT) begin
                state     <= IDLE;
                FRAME_IDX <= FRAME_IDX + 8'd1;
              end else begin
                state <= BB_WAIT;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t2mi_frame_scheduler.sv
// Directed bench for t2mi_frame_scheduler: L1_LEN=67, BB_PER_FRAME=2, BB_LEN=16, L1_TIMEOUT=10.
module tb_t2mi_frame_scheduler;

  localparam int L1_LEN       = 67;
  localparam int BB_PER_FRAME = 2;
  localparam int BB_LEN       = 16;
  localparam int L1_TIMEOUT   = 10;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       FRAME_TICK = 1'b0;
  logic [7:0] L1_DATA = 8'h00;
  logic       L1_LOAD = 1'b0;
  logic       BB_READY = 1'b0;
  logic [7:0] BB_DATA = 8'h00;
  logic       BB_VALID = 1'b0;
  logic       L1_REQ, BB_REQ, OUT_LOAD, OUT_SOF, OUT_EOF, OVERRUN, L1_ERR;
  logic [7:0] OUT_DATA, OUT_TYPE, FRAME_IDX;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_idx  = 8'h00;

  always #5 CLK = ~CLK;

  t2mi_frame_scheduler #(
    .L1_LEN(L1_LEN), .BB_PER_FRAME(BB_PER_FRAME), .BB_LEN(BB_LEN), .L1_TIMEOUT(L1_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST), .FRAME_TICK(FRAME_TICK), .L1_REQ(L1_REQ),
    .L1_DATA(L1_DATA), .L1_LOAD(L1_LOAD), .BB_READY(BB_READY), .BB_REQ(BB_REQ),
    .BB_DATA(BB_DATA), .BB_VALID(BB_VALID), .OUT_DATA(OUT_DATA), .OUT_LOAD(OUT_LOAD),
    .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF), .OUT_TYPE(OUT_TYPE), .FRAME_IDX(FRAME_IDX),
    .OVERRUN(OVERRUN), .L1_ERR(L1_ERR)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_idx = 8'h00;
  endtask

  // Frame tick, L1_START (with a byte that must be dropped), then nbytes of L1 payload.
  task automatic start_frame(input logic [7:0] seed, input int nbytes);
    logic [7:0] d;
    FRAME_TICK = 1'b1;
    step();
    FRAME_TICK = 1'b0;
    checks++;
    if (L1_REQ !== 1'b1) begin
      failures++;
      $display("[TB] FAIL l1_req_pulse: L1_REQ=%b want 1", L1_REQ);
    end
    L1_DATA = 8'hEE;
    L1_LOAD = 1'b1;
    step();
    checks++;
    if (L1_REQ !== 1'b0 || OUT_LOAD !== 1'b0) begin
      failures++;
      $display("[TB] FAIL l1_start_drop: L1_REQ=%b OUT_LOAD=%b want 0/0", L1_REQ, OUT_LOAD);
    end
    for (int i = 0; i < nbytes; i++) begin
      d = seed + 8'(i);
      L1_DATA = d;
      L1_LOAD = 1'b1;
      step();
      checks++;
      if (OUT_LOAD !== 1'b1 || OUT_DATA !== d || OUT_SOF !== (i == 0) ||
          OUT_EOF !== (i == L1_LEN - 1) || OUT_TYPE !== 8'h10) begin
        failures++;
        $display("[TB] FAIL l1_byte[%0d]: load=%b data=%h sof=%b eof=%b type=%h want 1/%h/%b/%b/10",
                 i, OUT_LOAD, OUT_DATA, OUT_SOF, OUT_EOF, OUT_TYPE, d, i == 0, i == L1_LEN - 1);
      end
    end
    L1_LOAD = 1'b0;
  endtask

  // Raise BB_READY, expect BB_REQ one cycle later, then drain one BBFRAME.
  task automatic bb_packet(input logic [7:0] seed, input bit gap, input int tick_at);
    int n;
    logic [7:0] d;
    n = 0;
    BB_READY = 1'b1;
    while (BB_REQ !== 1'b1 && n < 8) begin
      step();
      n++;
      checks++;
      if (OUT_LOAD !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bb_wait_idle: OUT_LOAD=%b want 0", OUT_LOAD);
      end
    end
    BB_READY = 1'b0;
    checks++;
    if (n !== 1) begin
      failures++;
      $display("[TB] FAIL bb_req_rise: BB_REQ high after %0d cycles want 1", n);
    end
    for (int i = 0; i < BB_LEN; i++) begin
      d = seed + 8'(i);
      BB_DATA = d;
      BB_VALID = 1'b1;
      FRAME_TICK = (i == tick_at);
      step();
      FRAME_TICK = 1'b0;
      BB_VALID = 1'b0;
      checks++;
      if (OUT_LOAD !== 1'b1 || OUT_DATA !== d || OUT_SOF !== (i == 0) ||
          OUT_EOF !== (i == BB_LEN - 1) || OUT_TYPE !== 8'h00) begin
        failures++;
        $display("[TB] FAIL bb_byte[%0d]: load=%b data=%h sof=%b eof=%b type=%h want 1/%h/%b/%b/00",
                 i, OUT_LOAD, OUT_DATA, OUT_SOF, OUT_EOF, OUT_TYPE, d, i == 0, i == BB_LEN - 1);
      end
      if (i == BB_LEN - 1) begin
        checks++;
        if (BB_REQ !== 1'b0 || L1_REQ !== 1'b0) begin
          failures++;
          $display("[TB] FAIL bb_req_fall: BB_REQ=%b L1_REQ=%b want 0/0", BB_REQ, L1_REQ);
        end
      end else if (gap) begin
        step();
        checks++;
        if (OUT_LOAD !== 1'b0) begin
          failures++;
          $display("[TB] FAIL bb_gap[%0d]: OUT_LOAD=%b want 0", i, OUT_LOAD);
        end
      end
    end
  endtask

  // One complete frame; the tick is injected at byte tick_i of packet tick_p (-1 = never).
  task automatic run_frame(input logic [7:0] seed, input bit gap, input int tick_p, input int tick_i);
    start_frame(seed, L1_LEN);
    BB_DATA = 8'hDD;
    BB_VALID = 1'b1;
    step();
    BB_VALID = 1'b0;
    checks++;
    if (OUT_LOAD !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bb_wait_drop: OUT_LOAD=%b want 0", OUT_LOAD);
    end
    for (int p = 0; p < BB_PER_FRAME; p++)
      bb_packet(seed + 8'h40 + 8'(p * BB_LEN), gap, (p == tick_p) ? tick_i : -1);
    exp_idx = exp_idx + 8'd1;
    step();
    checks++;
    if (FRAME_IDX !== exp_idx) begin
      failures++;
      $display("[TB] FAIL frame_idx: FRAME_IDX=%0d want %0d", FRAME_IDX, exp_idx);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    checks++;
    if (OUT_DATA !== 8'h00 || OUT_LOAD !== 1'b0 || OUT_SOF !== 1'b0 || OUT_EOF !== 1'b0 || OUT_TYPE !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_out: data=%h load=%b sof=%b eof=%b type=%h want all 0",
               OUT_DATA, OUT_LOAD, OUT_SOF, OUT_EOF, OUT_TYPE);
    end
    checks++;
    if (L1_REQ !== 1'b0 || BB_REQ !== 1'b0 || FRAME_IDX !== 8'h00 || OVERRUN !== 1'b0 || L1_ERR !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctl: l1_req=%b bb_req=%b idx=%h overrun=%b l1_err=%b want all 0",
               L1_REQ, BB_REQ, FRAME_IDX, OVERRUN, L1_ERR);
    end
    RST = 1'b0;
    exp_idx = 8'h00;
  endtask

  task automatic test_basic();
    run_frame(8'h30, 1'b0, -1, -1);
    checks++;
    if (FRAME_IDX !== 8'd1 || OVERRUN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_frame: idx=%0d overrun=%b want 1/0", FRAME_IDX, OVERRUN);
    end
  endtask

  task automatic test_gapped();
    run_frame(8'h90, 1'b1, -1, -1);
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int f = 0; f < 256; f++) begin
      run_frame(8'(f), 1'b0, -1, -1);
      if (f == 254) begin
        checks++;
        if (FRAME_IDX !== 8'hFF) begin
          failures++;
          $display("[TB] FAIL wrap_255: FRAME_IDX=%0d want 255", FRAME_IDX);
        end
      end
    end
    checks++;
    if (FRAME_IDX !== 8'h00 || OVERRUN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wrap_0: FRAME_IDX=%0d OVERRUN=%b want 0/0", FRAME_IDX, OVERRUN);
    end
  endtask

  task automatic test_overrun();
    run_frame(8'h50, 1'b0, 0, 5);
    checks++;
    if (OVERRUN !== 1'b1 || FRAME_IDX !== 8'd1) begin
      failures++;
      $display("[TB] FAIL overrun_set: OVERRUN=%b FRAME_IDX=%0d want 1/1", OVERRUN, FRAME_IDX);
    end
    run_frame(8'h70, 1'b0, -1, -1);
    checks++;
    if (OVERRUN !== 1'b1) begin
      failures++;
      $display("[TB] FAIL overrun_sticky: OVERRUN=%b want 1", OVERRUN);
    end
  endtask

  task automatic test_last_byte_tick();
    pulse_reset();
    checks++;
    if (OVERRUN !== 1'b0) begin
      failures++;
      $display("[TB] FAIL overrun_clear: OVERRUN=%b want 0", OVERRUN);
    end
    run_frame(8'h60, 1'b0, BB_PER_FRAME - 1, BB_LEN - 1);
    checks++;
    if (OVERRUN !== 1'b1 || L1_REQ !== 1'b0) begin
      failures++;
      $display("[TB] FAIL last_byte_tick: OVERRUN=%b L1_REQ=%b want 1/0", OVERRUN, L1_REQ);
    end
  endtask

  task automatic test_l1_timeout();
    pulse_reset();
    start_frame(8'h20, 30);
`ifdef L1_TIMEOUT_EN
    for (int c = 0; c < L1_TIMEOUT - 1; c++) step();
    checks++;
    if (L1_ERR !== 1'b0) begin
      failures++;
      $display("[TB] FAIL l1_err_early: L1_ERR=%b want 0", L1_ERR);
    end
    step();
    checks++;
    if (L1_ERR !== 1'b1 || OUT_LOAD !== 1'b0 || OUT_EOF !== 1'b0) begin
      failures++;
      $display("[TB] FAIL l1_timeout: L1_ERR=%b OUT_LOAD=%b OUT_EOF=%b want 1/0/0", L1_ERR, OUT_LOAD, OUT_EOF);
    end
    for (int p = 0; p < BB_PER_FRAME; p++)
      bb_packet(8'hA0 + 8'(p * BB_LEN), 1'b0, -1);
    exp_idx = exp_idx + 8'd1;
    step();
    checks++;
    if (FRAME_IDX !== exp_idx || L1_ERR !== 1'b1) begin
      failures++;
      $display("[TB] FAIL timeout_frame: FRAME_IDX=%0d L1_ERR=%b want %0d/1", FRAME_IDX, L1_ERR, exp_idx);
    end
`else
    BB_READY = 1'b1;
    for (int c = 0; c < 20; c++) step();
    BB_READY = 1'b0;
    checks++;
    if (BB_REQ !== 1'b0 || L1_ERR !== 1'b0 || OUT_LOAD !== 1'b0) begin
      failures++;
      $display("[TB] FAIL l1_stall: BB_REQ=%b L1_ERR=%b OUT_LOAD=%b want 0/0/0", BB_REQ, L1_ERR, OUT_LOAD);
    end
`endif
  endtask

  task automatic test_reset_mid_bb();
    pulse_reset();
    start_frame(8'h11, L1_LEN);
    BB_READY = 1'b1;
    step();
    BB_READY = 1'b0;
    checks++;
    if (BB_REQ !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_bb_req: BB_REQ=%b want 1", BB_REQ);
    end
    for (int i = 0; i < 5; i++) begin
      BB_DATA = 8'hC0 + 8'(i);
      BB_VALID = 1'b1;
      step();
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    BB_VALID = 1'b0;
    exp_idx = 8'h00;
    checks++;
    if (OUT_DATA !== 8'h00 || OUT_LOAD !== 1'b0 || OUT_SOF !== 1'b0 || OUT_EOF !== 1'b0 || OUT_TYPE !== 8'h00) begin
      failures++;
      $display("[TB] FAIL mid_reset_out: data=%h load=%b sof=%b eof=%b type=%h want all 0",
               OUT_DATA, OUT_LOAD, OUT_SOF, OUT_EOF, OUT_TYPE);
    end
    checks++;
    if (L1_REQ !== 1'b0 || BB_REQ !== 1'b0 || FRAME_IDX !== 8'h00 || OVERRUN !== 1'b0 || L1_ERR !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_ctl: l1_req=%b bb_req=%b idx=%h overrun=%b l1_err=%b want all 0",
               L1_REQ, BB_REQ, FRAME_IDX, OVERRUN, L1_ERR);
    end
    step();
    checks++;
    if (OUT_LOAD !== 1'b0 || OUT_EOF !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset_no_eof: OUT_LOAD=%b OUT_EOF=%b want 0/0", OUT_LOAD, OUT_EOF);
    end
    run_frame(8'h05, 1'b0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_wrap();
    test_overrun();
    test_last_byte_tick();
    test_l1_timeout();
    test_reset_mid_bb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
